fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single 8-bit write port of the team's synchronous FIFO between NREQ producers.
- Grants one producer at a time and lets it write a burst of up to MAX_BURST beats.
- Stalls on FIFO full, then hands over to the next requester with no idle bubble.
- Sits directly in front of the fifo block: drives its wr and data_in, and observes its full and fifo_cnt.

---
 rtl/fifo_wr_arbiter.sv | 146 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing the single write port of a synchronous FIFO
//   between NREQ producers. One producer owns the port at a time and may
//   write a burst of up to MAX_BURST beats before the grant rotates.
//   Handover to the next requester happens in the release cycle, so there
//   is no idle bubble between owners.
//
//   Optional build macro: FIFO_ARB_WM_EN
//     defined   : writes are also blocked once fifo_cnt >= AF_LEVEL
//     undefined : only fifo_full blocks writes (fifo_cnt, AF_LEVEL unused)
//
// Handshake: producer i holds req[i] and din[i] stable until ack[i]; a beat
//   transfers in any cycle where ack[i]=1. wr is asserted exactly with the
//   accepted beat and data_in carries that producer's word.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-low
//   req        per-producer level request
//   din        packed producer data, din[i*DW +: DW] = producer i
//   gnt        registered one-hot grant (all-zero when idle)
//   ack        beat accepted from producer i this cycle
//   busy       1 while a producer owns the port (FSM state visible here)
//   fifo_full  FIFO full flag
//   fifo_cnt   FIFO occupancy
//   wr         FIFO write strobe
//   data_in    FIFO write data
module fifo_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int DW        = 8,
   parameter int CW        = 4,
   parameter int MAX_BURST = 4,
   parameter int AF_LEVEL  = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] din,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    ack,
   output logic               busy,
   input  logic               fifo_full,
   input  logic [CW-1:0]      fifo_cnt,
   output logic               wr,
   output logic [DW-1:0]      data_in
);

   localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_OWN  = 1'b1;

   localparam logic [3:0]    LAST_BEAT = 4'(MAX_BURST - 1);
   localparam logic [OW-1:0] LAST_REQ  = OW'(NREQ - 1);

   logic [0:0]    state;
   logic [OW-1:0] owner;
   logic [OW-1:0] ptr;
   logic [3:0]    beat_cnt;

   logic          block;
   logic          owner_req;
   logic          beat;
   logic          release_own;
   logic [OW-1:0] owner_next;
   logic [OW-1:0] arb_start;
   logic          arb_found;
   logic [OW-1:0] arb_win;
   int            arb_idx;

`ifdef FIFO_ARB_WM_EN
   // Throttle at the watermark so a registered writer downstream never overruns.
   assign block = fifo_full || (fifo_cnt >= CW'(AF_LEVEL));
`else
   logic unused_wm;
   assign block     = fifo_full;
   assign unused_wm = ^{fifo_cnt, CW'(AF_LEVEL)};
`endif

   assign owner_req   = req[owner];
   // rst gates the beat so wr/ack drop the moment reset is asserted.
   assign beat        = rst && (state == ST_OWN) && owner_req && !block;
   // A dropped request (no beat possible) or the final beat ends ownership.
   assign release_own = (state == ST_OWN) &&
                        (!owner_req || (beat && (beat_cnt == LAST_BEAT)));
   assign owner_next  = (owner == LAST_REQ) ? '0 : owner + OW'(1);

   // Circular search; on release it starts just past the old owner, so the
   // old owner is re-granted only when nobody else is requesting.
   assign arb_start = release_own ? owner_next : ptr;

   always_comb begin
      arb_found = 1'b0;
      arb_win   = '0;
      arb_idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         arb_idx = int'(arb_start) + k;
         if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
         if (!arb_found && req[arb_idx]) begin
            arb_found = 1'b1;
            arb_win   = OW'(arb_idx);
         end
      end
   end

   assign wr      = beat;
   assign ack     = beat ? (NREQ'(1) << owner) : '0;
   assign busy    = (state == ST_OWN);
   assign data_in = (state == ST_OWN) ? din[int'(owner)*DW +: DW] : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_IDLE;
         gnt      <= '0;
         owner    <= '0;
         ptr      <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (arb_found) begin
                  state <= ST_OWN;
                  owner <= arb_win;
                  gnt   <= NREQ'(1) << arb_win;
               end
            end
            default: begin
               if (release_own) begin
                  ptr      <= owner_next;
                  beat_cnt <= '0;
                  if (arb_found) begin
                     owner <= arb_win;
                     gnt   <= NREQ'(1) << arb_win;
                  end else begin
                     state <= ST_IDLE;
                     gnt   <= '0;
                  end
               end else if (beat) begin
                  beat_cnt <= beat_cnt + 4'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with a data scoreboard.
// Producer i presents word {i, seq[i]} and advances seq[i] on each ack.
// A small FIFO occupancy model feeds fifo_full / fifo_cnt back to the DUT.
module tb_fifo_wr_arbiter;

   localparam int NREQ      = 4;
   localparam int DW        = 8;
   localparam int CW        = 4;
   localparam int MAX_BURST = 4;
   localparam int AF_LEVEL  = 6;
   localparam int FDEPTH    = 8;

   logic               clk;
   logic               rst;
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] din;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    ack;
   logic               busy;
   logic               fifo_full;
   logic [CW-1:0]      fifo_cnt;
   logic               wr;
   logic [DW-1:0]      data_in;

   int   seq [NREQ];
   int   fcnt;
   logic full_force;
   logic drain;

   logic [NREQ-1:0] s_gnt;
   logic [NREQ-1:0] s_ack;
   logic            s_wr;
   logic            s_busy;
   logic [DW-1:0]   s_data;

   logic [DW-1:0] exp_q[$];
   int n_chk;
   int n_err;
   int nwr;

   fifo_wr_arbiter #(
      .NREQ(NREQ), .DW(DW), .CW(CW), .MAX_BURST(MAX_BURST), .AF_LEVEL(AF_LEVEL)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt), .ack(ack),
      .busy(busy), .fifo_full(fifo_full), .fifo_cnt(fifo_cnt), .wr(wr),
      .data_in(data_in)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign fifo_full = full_force || (fcnt >= FDEPTH);
   assign fifo_cnt  = CW'(fcnt);

   function automatic logic [DW-1:0] pw(int i, int s);
      return {3'(i), 5'(s)};
   endfunction

   always_comb begin
      din = '0;
      for (int i = 0; i < NREQ; i++) din[i*DW +: DW] = pw(i, seq[i]);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_beats(input int p, input int s0, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(pw(p, s0 + k));
   endtask

   // One clock cycle: sample at negedge, score writes, update models after posedge.
   task automatic tick();
      logic [DW-1:0] e;
      @(negedge clk);
      s_gnt  = gnt;
      s_ack  = ack;
      s_wr   = wr;
      s_busy = busy;
      s_data = data_in;
      if (s_wr) begin
         if (exp_q.size() == 0) begin
            check("unexp_wr", 32'(s_wr), 0);
         end else begin
            e = exp_q.pop_front();
            check("wr_data", 32'(s_data), 32'(e));
            check("wr_ack", 32'(s_ack), 32'(NREQ'(1) << e[DW-1:5]));
            nwr++;
         end
      end else begin
         check("idle_ack", 32'(s_ack), 0);
      end
      @(posedge clk);
      #1;
      if (drain && fcnt > 0) fcnt = fcnt - 1;
      if (s_wr) fcnt = fcnt + 1;
      for (int i = 0; i < NREQ; i++) if (s_ack[i]) seq[i] = seq[i] + 1;
   endtask

   task automatic do_reset();
      rst        = 1'b0;
      req        = '0;
      full_force = 1'b0;
      drain      = 1'b0;
      tick();
      tick();
      fcnt = 0;
      for (int i = 0; i < NREQ; i++) seq[i] = 0;
      rst = 1'b1;
      nwr = 0;
   endtask

   task automatic idle_wait(input string tag);
      req = '0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (!s_busy) break;
      end
      check({tag, "_idle"}, 32'(s_busy), 0);
      check({tag, "_left"}, exp_q.size(), 0);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      nwr   = 0;
      fcnt  = 0;
      for (int i = 0; i < NREQ; i++) seq[i] = 0;
      full_force = 1'b0;
      drain      = 1'b0;

      // Reset held 3 cycles with all producers requesting.
      rst = 1'b0;
      req = 4'b1111;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("rst_gnt", 32'(s_gnt), 0);
         check("rst_wr", 32'(s_wr), 0);
         check("rst_busy", 32'(s_busy), 0);
      end
      rst = 1'b1;
      push_beats(0, 0, 1);
      tick();
      check("post_rst_gnt0", 32'(s_gnt), 0);
      tick();
      check("post_rst_gnt1", 32'(s_gnt), 32'(4'b0001));
      idle_wait("rst");

      // Single requester: burst of 4, then re-grant with no bubble.
      do_reset();
      req = 4'b0001;
      push_beats(0, 0, 5);
      for (int c = 1; c <= 6; c++) begin
         tick();
         check("solo_gnt", 32'(s_gnt), (c == 1) ? 0 : 32'(4'b0001));
      end
      check("solo_nobubble", 32'(s_wr), 1);
      check("solo_nwr", nwr, 5);
      idle_wait("solo");

      // Three requesters: order 0,1,3,0, 4 beats each, back to back.
      do_reset();
      drain = 1'b1;
      req   = 4'b1011;
      push_beats(0, 0, 4);
      push_beats(1, 0, 4);
      push_beats(3, 0, 4);
      push_beats(0, 4, 4);
      for (int c = 1; c <= 17; c++) begin
         logic [NREQ-1:0] eg;
         if (c == 1)       eg = 4'b0000;
         else if (c <= 5)  eg = 4'b0001;
         else if (c <= 9)  eg = 4'b0010;
         else if (c <= 13) eg = 4'b1000;
         else              eg = 4'b0001;
         tick();
         check("rr_gnt", 32'(s_gnt), 32'(eg));
      end
      check("rr_nwr", nwr, 16);
      // Reset mid-burst: owner 1 is requesting but wr must stay low.
      rst = 1'b0;
      tick();
      check("midrst_wr", 32'(s_wr), 0);
      tick();
      check("midrst_gnt", 32'(s_gnt), 0);
      check("midrst_busy", 32'(s_busy), 0);
      check("midrst_left", exp_q.size(), 0);

      // FIFO full stall during producer 2's burst, then handover to 3.
      do_reset();
      req = 4'b1100;
      push_beats(2, 0, 4);
      push_beats(3, 0, 1);
      tick();
      tick();
      tick();
      check("stall_pre_gnt", 32'(s_gnt), 32'(4'b0100));
      full_force = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("stall_wr", 32'(s_wr), 0);
         check("stall_gnt", 32'(s_gnt), 32'(4'b0100));
      end
      full_force = 1'b0;
      tick();
      tick();
      check("stall_resume_gnt", 32'(s_gnt), 32'(4'b0100));
      tick();
      check("stall_hand_gnt", 32'(s_gnt), 32'(4'b1000));
      check("stall_nwr", nwr, 5);
      idle_wait("stall");

      // Owner 1 drops after one beat; owner 3 then gets a full fresh burst.
      do_reset();
      req = 4'b1010;
      push_beats(1, 0, 1);
      push_beats(3, 0, 4);
      push_beats(0, 0, 1);
      tick();
      tick();
      check("drop_gnt1", 32'(s_gnt), 32'(4'b0010));
      req = 4'b1001;
      tick();
      check("drop_rel_gnt", 32'(s_gnt), 32'(4'b0010));
      check("drop_rel_wr", 32'(s_wr), 0);
      for (int c = 4; c <= 7; c++) begin
         tick();
         check("drop_gnt3", 32'(s_gnt), 32'(4'b1000));
      end
      tick();
      check("drop_next_gnt", 32'(s_gnt), 32'(4'b0001));
      idle_wait("drop");

      // Watermark: FIFO preloaded with 5 entries.
      do_reset();
      fcnt = 5;
      req  = 4'b0001;
`ifdef FIFO_ARB_WM_EN
      push_beats(0, 0, 1);
`else
      push_beats(0, 0, 3);
`endif
      for (int c = 0; c < 7; c++) tick();
`ifdef FIFO_ARB_WM_EN
      check("wm_nwr", nwr, 1);
      check("wm_cnt", fcnt, AF_LEVEL);
`else
      check("wm_nwr", nwr, 3);
      check("wm_cnt", fcnt, FDEPTH);
`endif
      check("wm_stall_wr", 32'(s_wr), 0);
      check("wm_gnt", 32'(s_gnt), 32'(4'b0001));
      idle_wait("wm");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
